// File: rtl/tqvp_prism_cfg_seq.sv
// tqvp_prism_cfg_seq: queues host config words and replays them as PRISM debug writes under reset
module tqvp_prism_cfg_seq #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int SETTLE = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic                     go,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     prism_reset,
    output logic                     prism_enable,
    output logic                     dbg_wr,
    output logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_wdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, HOLD, LOAD, RELEASE} state_t;

    state_t                     state, state_nx;
    logic [PW-1:0]              wr_ptr, rd_ptr, level_nx;
    logic [CW-1:0]              cnt;
    logic [ADDR_W+DATA_W-1:0]   mem [DEPTH];
    logic                       push, pop;

    assign push = cmd_valid & cmd_ready & ~abort;

    // next-state and pop decision; abort overrides everything
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE:    state_nx = go ? HOLD : IDLE;
            HOLD:    if (cnt == CW'(SETTLE - 1)) state_nx = (level == '0) ? RELEASE : LOAD;
            LOAD: begin
                pop = 1'b1;
                if (level == PW'(1)) state_nx = RELEASE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            pop      = 1'b0;
        end
        level_nx = abort ? '0 : level + PW'(push) - PW'(pop);
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {cmd_addr, cmd_data};
    end

    // control registers, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            level        <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            dbg_wr       <= 1'b0;
            dbg_addr     <= '0;
            dbg_wdata    <= '0;
            prism_reset  <= 1'b1;
            prism_enable <= 1'b0;
        end else begin
            state     <= state_nx;
            level     <= level_nx;
            busy      <= state_nx != IDLE;
            cmd_ready <= (state_nx == IDLE) && (level_nx < PW'(DEPTH));
            cnt       <= (state == HOLD) ? cnt + CW'(1) : '0;
            wr_ptr    <= abort ? '0 : wr_ptr + PW'(push);
            rd_ptr    <= abort ? '0 : rd_ptr + PW'(pop);
            dbg_wr    <= pop;
            done      <= (state == RELEASE) && !abort;
            if (pop) {dbg_addr, dbg_wdata} <= mem[rd_ptr[AW-1:0]];
            if (abort || (state == IDLE && go)) begin
                prism_reset  <= 1'b1;
                prism_enable <= 1'b0;
            end else if (state == RELEASE) begin
                prism_reset  <= 1'b0;
                prism_enable <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tqvp_prism_cfg_seq.sv
// tb_tqvp_prism_cfg_seq: randomized scoreboard bench for the PRISM config sequencer
module tb_tqvp_prism_cfg_seq;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 3;

    typedef struct {
        logic [37:0] w;
        int          stamp;
    } ew_t;

    logic        clk, rst_n, cmd_valid, cmd_ready, go, abort, busy, done;
    logic        prism_reset, prism_enable, dbg_wr;
    logic [5:0]  cmd_addr, dbg_addr;
    logic [31:0] cmd_data, dbg_wdata;
    logic [2:0]  level;

    tqvp_prism_cfg_seq #(.DEPTH(DEPTH), .ADDR_W(6), .DATA_W(32), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .go(go), .abort(abort),
        .busy(busy), .done(done), .level(level), .prism_reset(prism_reset),
        .prism_enable(prism_enable), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata)
    );

    int          n_chk = 0, n_pass = 0, cyc = 0, done_stamp = 0;
    logic        model_busy = 0, model_en = 0, last_acc = 0, mexp;
    logic [37:0] q[$];
    ew_t         exp_wr[$];

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    endtask

    // reference model: writes land SETTLE+1 edges after go, back to back, done right after
    task automatic step(input logic v, input logic [5:0] a, input logic [31:0] d,
                        input logic g, input logic ab);
        cmd_valid = v; cmd_addr = a; cmd_data = d; go = g; abort = ab;
        @(posedge clk);
        last_acc = 0;
        if (ab) begin
            q.delete(); exp_wr.delete(); model_busy = 0; model_en = 0;
        end else begin
            if (v && !model_busy && q.size() < DEPTH) begin
                q.push_back({a, d});
                last_acc = 1;
            end
            if (g && !model_busy) begin
                model_busy = 1; model_en = 0;
                foreach (q[i]) exp_wr.push_back('{q[i], cyc + SETTLE + 2 + i});
                done_stamp = cyc + SETTLE + 2 + q.size();
                q.delete();
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && model_busy; i++) step(0, 0, 0, 0, 0);
        chk("seq_timeout", model_busy, 0);
    endtask

    task automatic rst_chk();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_level", level, 0);
        chk("rst_dbg_wr", dbg_wr, 0);
        chk("rst_prism_reset", prism_reset, 1);
        chk("rst_prism_enable", prism_enable, 0);
    endtask

    // monitor: compares every DUT output against the model state each cycle
    always @(negedge clk) begin
        if (rst_n) begin
            mexp = model_busy && cyc == done_stamp;
            chk("done", done, mexp);
            if (mexp) begin
                model_busy = 0;
                model_en   = 1;
            end
            if (exp_wr.size() > 0 && exp_wr[0].stamp == cyc) begin
                chk("dbg_wr", dbg_wr, 1);
                chk("dbg_word", {dbg_addr, dbg_wdata}, exp_wr[0].w);
                void'(exp_wr.pop_front());
            end else begin
                chk("dbg_wr_quiet", dbg_wr, 0);
            end
            chk("busy", busy, model_busy);
            chk("prism_reset", prism_reset, !model_en);
            chk("prism_enable", prism_enable, model_en);
            chk("cmd_ready", cmd_ready, !model_busy && q.size() < DEPTH);
            if (!model_busy) chk("level", level, q.size());
        end
    end

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_addr = 0; cmd_data = 0; go = 0; abort = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_chk();
        chk("rst_dbg_addr", dbg_addr, 0);
        chk("rst_dbg_wdata", dbg_wdata, 0);
        rst_n = 1;
        idle(2);
        // two words replayed in push order
        step(1, 6'h04, 32'hDEADBEEF, 0, 0);
        step(1, 6'h08, 32'h12345678, 0, 0);
        step(0, 0, 0, 1, 0);
        wait_idle();
        idle(2);
        // full FIFO: fifth word stalls until the sequence drains the queue
        for (int i = 0; i < 4; i++) step(1, 6'(i + 16), $urandom, 0, 0);
        idle(1);
        chk("full_level", level, 4);
        chk("full_ready", cmd_ready, 0);
        for (int i = 0; i < 3; i++) step(1, 6'h3F, 32'hCAFEF00D, 0, 0);
        step(1, 6'h3F, 32'hCAFEF00D, 1, 0);
        for (int i = 0; i < 40 && !last_acc; i++) step(1, 6'h3F, 32'hCAFEF00D, 0, 0);
        chk("fifth_accepted", last_acc, 1);
        step(0, 0, 0, 1, 0);
        wait_idle();
        // empty sequence
        step(0, 0, 0, 1, 0);
        wait_idle();
        // abort after the first of three writes
        for (int i = 0; i < 3; i++) step(1, 6'(i + 32), $urandom, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(SETTLE + 1);
        step(0, 0, 0, 0, 1);
        idle(3);
        // go while busy is ignored; go with a same-cycle push includes the word
        step(1, 6'h11, 32'h11111111, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 6'h22, 32'h22222222, 1, 0);
        step(0, 0, 0, 1, 0);
        wait_idle();
        step(1, 6'h12, 32'h12121212, 0, 0);
        step(1, 6'h13, 32'h13131313, 1, 0);
        wait_idle();
        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            for (int k = $urandom_range(0, 5); k > 0; k--) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                step(1, 6'($urandom), $urandom, 0, 0);
            end
            step(1'($urandom_range(0, 1)), 6'($urandom), $urandom, 1, 0);
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(0, 8));
                step(0, 0, 0, 0, 1);
            end
            for (int i = 0; i < 60 && model_busy; i++)
                step(1'($urandom_range(0, 1)), 6'($urandom), $urandom,
                     1'($urandom_range(0, 5) == 0), 0);
            step(0, 0, 0, 0, 0);
            wait_idle();
        end
        // asynchronous reset mid-LOAD
        for (int i = 0; i < 3; i++) step(1, 6'(i + 40), $urandom, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(SETTLE + 1);
        #1;
        rst_n = 0;
        q.delete(); exp_wr.delete(); model_busy = 0; model_en = 0;
        #1;
        rst_chk();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        idle(2);
        step(1, 6'h2A, 32'hA5A5A5A5, 1, 0);
        wait_idle();
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
